// File: rtl/rtl_settings_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rtl_settings_pkg                                          |
// | Purpose  : Shared types and defaults for the test scheduler slice.   |
// |            Holds the scheduler state encoding and default FIFO depth.|
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package rtl_settings_pkg;

    // Default number of queued test descriptors.
    localparam int SCHED_DEPTH = 4;

    // Scheduler states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        WAIT   = 3'd2,
        GAP    = 3'd3,
        HALT   = 3'd4
    } sched_state_t;

endpackage : rtl_settings_pkg
`default_nettype wire

// File: rtl/desc_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : desc_fifo                                                 |
// | Purpose  : Synchronous descriptor FIFO with registered read data.    |
// | Ports    : clk, rst      clock / asynchronous active-high reset      |
// |            i_push        write request (dropped when full)           |
// |            i_pop         read request (ignored when empty)           |
// |            i_flush       empty the FIFO; beats push and pop          |
// |            i_data        write data                                  |
// |            o_full        no free entry                               |
// |            o_empty       no valid entry                              |
// |            o_level       occupancy                                   |
// |            o_data        registered head data, loaded on pop         |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module desc_fifo
    import rtl_settings_pkg::*;
#(
    parameter int DEPTH = SCHED_DEPTH,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  logic [WIDTH-1:0]           i_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_level,
    output logic [WIDTH-1:0]           o_data
);

    localparam int c_addr_w = $clog2(DEPTH);
    localparam int c_lvl_w  = $clog2(DEPTH+1);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [c_addr_w:0] r_wr_ptr;
    logic [c_addr_w:0] r_rd_ptr;
    logic [WIDTH-1:0]  r_data;

    logic              w_full;
    logic              w_empty;
    logic              w_do_push;
    logic              w_do_pop;
    logic [c_addr_w:0] w_diff;

    // Extra pointer MSB distinguishes full (MSBs differ) from empty.
    assign w_full    = (r_wr_ptr[c_addr_w] != r_rd_ptr[c_addr_w]) &&
                       (r_wr_ptr[c_addr_w-1:0] == r_rd_ptr[c_addr_w-1:0]);
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_do_push = i_push && !w_full && !i_flush;
    assign w_do_pop  = i_pop && !w_empty && !i_flush;
    assign w_diff    = r_wr_ptr - r_rd_ptr;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[c_addr_w-1:0]] <= i_data;
        end
    end

    // Read data is not cleared by a flush so the launched parameters stay
    // stable on the control block until the next launch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_data   <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_data   <= r_mem[r_rd_ptr[c_addr_w-1:0]];
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_level = c_lvl_w'(w_diff);
    assign o_data  = r_data;

endmodule : desc_fifo
`default_nettype wire

// File: rtl/test_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : test_scheduler                                            |
// | Purpose  : Queues memory-test descriptors from CSR and launches them |
// |            one at a time on the control block, counting pass/fail   |
// |            results and guarding each test with a watchdog.           |
// | Ports    : rst_i, clk_i          async reset / clock                 |
// |            desc_valid_i, desc_i  descriptor push; desc_ready_o=!full |
// |            run_i, abort_i        launch enable / queue flush         |
// |            stop_on_fail_i        halt on first failing result        |
// |            clear_i               clear counters and timeout flag     |
// |            timeout_i             watchdog limit, 0 disables          |
// |            start_test_o, test_param_o  launch to control block       |
// |            test_finished_i, test_result_i  completion from control   |
// |            busy_o, level_o, pass_cnt_o, fail_cnt_o, timeout_o, done_o|
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module test_scheduler
    import rtl_settings_pkg::*;
#(
    parameter int DEPTH = SCHED_DEPTH,
    parameter int CNT_W = 16
) (
    input  logic                       rst_i,
    input  logic                       clk_i,
    input  logic                       desc_valid_i,
    input  logic [2:1][31:0]           desc_i,
    output logic                       desc_ready_o,
    input  logic                       run_i,
    input  logic                       abort_i,
    input  logic                       stop_on_fail_i,
    input  logic                       clear_i,
    input  logic [31:0]                timeout_i,
    output logic                       start_test_o,
    output logic [2:1][31:0]           test_param_o,
    input  logic                       test_finished_i,
    input  logic                       test_result_i,
    output logic                       busy_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o,
    output logic [CNT_W-1:0]           pass_cnt_o,
    output logic [CNT_W-1:0]           fail_cnt_o,
    output logic                       timeout_o,
    output logic                       done_o
);

    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    sched_state_t     r_state;
    sched_state_t     w_next;
    logic [31:0]      r_wdog;
    logic [CNT_W-1:0] r_pass_cnt;
    logic [CNT_W-1:0] r_fail_cnt;
    logic             r_timeout;

    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_flush;
    logic             w_start;
    logic             w_pass_inc;
    logic             w_fail_inc;
    logic             w_to_set;
    logic [31:0]      w_wdog_inc;
    logic             w_wdog_hit;
    logic [63:0]      w_head;

    desc_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_push  (desc_valid_i),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_data  (desc_i),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level_o),
        .o_data  (w_head)
    );

    // The count includes the current WAIT cycle, so the watchdog fires in
    // the timeout_i-th WAIT cycle unless a finish arrives in that cycle.
    assign w_wdog_inc = r_wdog + 32'd1;
    assign w_wdog_hit = (timeout_i != 32'd0) && (w_wdog_inc == timeout_i);

    always_comb begin
        w_next     = r_state;
        w_pop      = 1'b0;
        w_flush    = abort_i;
        w_start    = 1'b0;
        w_pass_inc = 1'b0;
        w_fail_inc = 1'b0;
        w_to_set   = 1'b0;
        case (r_state)
            IDLE: begin
                // Pop here so the registered head is ready in LAUNCH.
                if (run_i && !w_empty && !abort_i) begin
                    w_pop  = 1'b1;
                    w_next = LAUNCH;
                end
            end
            LAUNCH: begin
                // An abort while the launch is pending discards it.
                if (abort_i) begin
                    w_next = IDLE;
                end else begin
                    w_start = 1'b1;
                    w_next  = WAIT;
                end
            end
            WAIT: begin
                if (test_finished_i) begin
                    if (test_result_i) begin
                        w_fail_inc = 1'b1;
                        if (stop_on_fail_i) begin
                            w_flush = 1'b1;
                            w_next  = HALT;
                        end else begin
                            w_next = GAP;
                        end
                    end else begin
                        w_pass_inc = 1'b1;
                        w_next     = GAP;
                    end
                end else if (w_wdog_hit) begin
                    w_fail_inc = 1'b1;
                    w_to_set   = 1'b1;
                    w_flush    = 1'b1;
                    w_next     = HALT;
                end
            end
            GAP: begin
                w_next = IDLE;
            end
            HALT: begin
                if (!run_i) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wdog <= '0;
        end else if (r_state == LAUNCH) begin
            r_wdog <= '0;
        end else if (r_state == WAIT) begin
            r_wdog <= w_wdog_inc;
        end
    end

    // Saturating counters; clear beats a same-cycle increment.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
            r_timeout  <= 1'b0;
        end else if (clear_i) begin
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            if (w_pass_inc && (r_pass_cnt != '1)) begin
                r_pass_cnt <= r_pass_cnt + c_cnt_one;
            end
            if (w_fail_inc && (r_fail_cnt != '1)) begin
                r_fail_cnt <= r_fail_cnt + c_cnt_one;
            end
            if (w_to_set) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign desc_ready_o = !w_full;
    assign start_test_o = w_start;
    assign test_param_o = w_head;
    assign busy_o       = (r_state != IDLE);
    assign pass_cnt_o   = r_pass_cnt;
    assign fail_cnt_o   = r_fail_cnt;
    assign timeout_o    = r_timeout;
    assign done_o       = (r_state == GAP) && w_empty;

endmodule : test_scheduler
`default_nettype wire

// File: tb/tb_test_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_test_scheduler                                         |
// | Purpose  : Scoreboard bench for test_scheduler; the bench plays the  |
// |            CSR block and the control block.                          |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_test_scheduler;

    localparam int DEPTH = 4;
    // Narrow counters so saturation is reachable in a short run.
    localparam int CNT_W = 4;
    localparam int LVL_W = $clog2(DEPTH+1);

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             desc_valid_i;
    logic [2:1][31:0] desc_i;
    logic             desc_ready_o;
    logic             run_i;
    logic             abort_i;
    logic             stop_on_fail_i;
    logic             clear_i;
    logic [31:0]      timeout_i;
    logic             start_test_o;
    logic [2:1][31:0] test_param_o;
    logic             test_finished_i;
    logic             test_result_i;
    logic             busy_o;
    logic [LVL_W-1:0] level_o;
    logic [CNT_W-1:0] pass_cnt_o;
    logic [CNT_W-1:0] fail_cnt_o;
    logic             timeout_o;
    logic             done_o;

    test_scheduler #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .rst_i           (rst_i),
        .clk_i           (clk_i),
        .desc_valid_i    (desc_valid_i),
        .desc_i          (desc_i),
        .desc_ready_o    (desc_ready_o),
        .run_i           (run_i),
        .abort_i         (abort_i),
        .stop_on_fail_i  (stop_on_fail_i),
        .clear_i         (clear_i),
        .timeout_i       (timeout_i),
        .start_test_o    (start_test_o),
        .test_param_o    (test_param_o),
        .test_finished_i (test_finished_i),
        .test_result_i   (test_result_i),
        .busy_o          (busy_o),
        .level_o         (level_o),
        .pass_cnt_o      (pass_cnt_o),
        .fail_cnt_o      (fail_cnt_o),
        .timeout_o       (timeout_o),
        .done_o          (done_o)
    );

    always #5 clk_i = ~clk_i;

    int          nvec     = 0;
    int          nmis     = 0;
    int          launches = 0;
    int          done_cnt = 0;
    int          base;
    logic [63:0] sb_q [$];
    logic [63:0] mon_exp;

    // Monitor: every launch pulse must match the oldest expected descriptor.
    always @(negedge clk_i) begin
        if (done_o) done_cnt++;
        if (start_test_o) begin
            launches++;
            nvec++;
            if (sb_q.size() == 0) begin
                nmis++;
                $display("FAIL unexpected_launch: got param %h, expected no launch", test_param_o);
            end else begin
                mon_exp = sb_q.pop_front();
                if (test_param_o !== mon_exp) begin
                    nmis++;
                    $display("FAIL launch_param: got %h expected %h", test_param_o, mon_exp);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [31:0] p2, input logic [31:0] p1, input bit exp_launch);
        desc_valid_i = 1'b1;
        desc_i       = {p2, p1};
        if (exp_launch) sb_q.push_back({p2, p1});
        tick();
        desc_valid_i = 1'b0;
    endtask

    // Returns in a WAIT cycle once launch number k has been seen.
    task automatic wait_launch(input int k);
        int n;
        n = 0;
        while (launches < k && n < 40) begin
            tick();
            n++;
        end
        check("launch_seen", 64'(launches >= k), 64'd1);
    endtask

    task automatic finish(input int delay, input logic res);
        repeat (delay) tick();
        test_finished_i = 1'b1;
        test_result_i   = res;
        tick();
        test_finished_i = 1'b0;
        test_result_i   = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $fatal(1, "bench time limit");
    end

    initial begin
        rst_i = 1'b1; desc_valid_i = 1'b0; desc_i = '0; run_i = 1'b0;
        abort_i = 1'b0; stop_on_fail_i = 1'b0; clear_i = 1'b0; timeout_i = '0;
        test_finished_i = 1'b0; test_result_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("rst_desc_ready", desc_ready_o, 1);
        check("rst_busy",       busy_o, 0);
        check("rst_level",      level_o, 0);
        check("rst_pass",       pass_cnt_o, 0);
        check("rst_fail",       fail_cnt_o, 0);
        check("rst_timeout",    timeout_o, 0);
        check("rst_start",      start_test_o, 0);
        check("rst_param",      test_param_o, 0);
        tick();
        rst_i = 1'b0;
        tick();

        // Three passing tests back to back.
        done_cnt = 0;
        base = launches;
        run_i = 1'b1;
        push(32'hA000_0001, 32'd4, 1'b1);
        push(32'hA000_0002, 32'd8, 1'b1);
        push(32'hA000_0003, 32'd16, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            wait_launch(base + i);
            finish(2, 1'b0);
        end
        repeat (4) tick();
        check("s1_pass", pass_cnt_o, 3);
        check("s1_fail", fail_cnt_o, 0);
        check("s1_done_pulses", done_cnt, 1);
        check("s1_busy", busy_o, 0);
        run_i = 1'b0;

        // Fill beyond capacity with launching disabled.
        pulse_clear();
        check("s2_clear_pass", pass_cnt_o, 0);
        base = launches;
        for (int i = 0; i < 4; i++) push(32'hB000_0000, 32'(i), 1'b0);
        check("s2_ready_full", desc_ready_o, 0);
        check("s2_level_full", level_o, 4);
        push(32'hB000_0000, 32'd99, 1'b0);
        check("s2_level_drop", level_o, 4);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("s2_level_abort", level_o, 0);
        check("s2_ready_abort", desc_ready_o, 1);
        check("s2_no_launch", launches, base);

        // Stop on first failure.
        stop_on_fail_i = 1'b1;
        base = launches;
        push(32'hC000_0001, 32'd32, 1'b1);
        push(32'hC000_0002, 32'd64, 1'b1);
        push(32'hC000_0003, 32'd128, 1'b0);
        check("s3_level_queued", level_o, 3);
        run_i = 1'b1;
        wait_launch(base + 1);
        finish(1, 1'b0);
        wait_launch(base + 2);
        finish(1, 1'b1);
        check("s3_fail", fail_cnt_o, 1);
        check("s3_pass", pass_cnt_o, 1);
        check("s3_level_flushed", level_o, 0);
        repeat (4) tick();
        check("s3_halt_busy", busy_o, 1);
        check("s3_no_more_launch", launches, base + 2);
        run_i = 1'b0;
        tick();
        check("s3_idle", busy_o, 0);
        stop_on_fail_i = 1'b0;

        // Watchdog expiry after 10 WAIT cycles.
        pulse_clear();
        timeout_i = 32'd10;
        run_i = 1'b1;
        base = launches;
        push(32'hD000_0001, 32'd256, 1'b1);
        wait_launch(base + 1);
        repeat (8) tick();
        check("s4_no_timeout_c9", timeout_o, 0);
        tick();
        tick();
        check("s4_timeout", timeout_o, 1);
        check("s4_fail", fail_cnt_o, 1);
        check("s4_pass", pass_cnt_o, 0);
        check("s4_halt_busy", busy_o, 1);
        run_i = 1'b0;
        tick();
        check("s4_idle", busy_o, 0);

        // Finish in the same cycle the watchdog would fire.
        pulse_clear();
        check("s4b_timeout_cleared", timeout_o, 0);
        run_i = 1'b1;
        base = launches;
        push(32'hD000_0002, 32'd512, 1'b1);
        wait_launch(base + 1);
        finish(9, 1'b0);
        check("s4b_no_timeout", timeout_o, 0);
        check("s4b_pass", pass_cnt_o, 1);
        check("s4b_fail", fail_cnt_o, 0);
        tick();
        timeout_i = 32'd0;

        // Abort during WAIT with two descriptors still queued.
        pulse_clear();
        run_i = 1'b0;
        base = launches;
        push(32'hE000_0001, 32'd1, 1'b1);
        push(32'hE000_0002, 32'd2, 1'b0);
        push(32'hE000_0003, 32'd3, 1'b0);
        run_i = 1'b1;
        wait_launch(base + 1);
        check("s5_level_wait", level_o, 2);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("s5_level_abort", level_o, 0);
        done_cnt = 0;
        finish(2, 1'b0);
        check("s5_done_at_gap", done_o, 1);
        repeat (5) tick();
        check("s5_pass", pass_cnt_o, 1);
        check("s5_busy", busy_o, 0);
        check("s5_launches", launches, base + 1);
        check("s5_done_pulses", done_cnt, 1);

        // Counter saturation and clear beating an increment.
        pulse_clear();
        for (int i = 0; i < 15; i++) begin
            base = launches;
            push(32'hF000_0000, 32'(i), 1'b1);
            wait_launch(base + 1);
            finish(1, 1'b0);
        end
        check("s6_pass_max", pass_cnt_o, 15);
        base = launches;
        push(32'hF000_0001, 32'd77, 1'b1);
        wait_launch(base + 1);
        finish(1, 1'b0);
        check("s6_pass_sat", pass_cnt_o, 15);
        base = launches;
        push(32'hF000_0002, 32'd78, 1'b1);
        wait_launch(base + 1);
        test_finished_i = 1'b1;
        test_result_i   = 1'b0;
        clear_i         = 1'b1;
        tick();
        test_finished_i = 1'b0;
        clear_i         = 1'b0;
        check("s6_clear_wins", pass_cnt_o, 0);
        check("s6_fail_zero", fail_cnt_o, 0);
        run_i = 1'b0;
        repeat (3) tick();
        check("sb_drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule : tb_test_scheduler
`default_nettype wire
